mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-stage load/store unit directly downstream of the Execute->Memory pipeline register.
//  Consumes ILoadM/WBSelM/RegWEnM/MemRWM plus address/store data, drives a variable-latency
//  data-memory handshake, and stalls the pipeline until the access completes.
//  Performs byte-lane steering and byte enables for stores, and sign/zero extension for loads.
//  Reports misaligned accesses and bus timeouts.
// PARAMETERS
//  XLEN     32   data/address width
//  TIMEOUT  255  max cycles in REQ without dmem_ack before bus error; 0 = no timeout
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     reset, asynchronous, active-high
//  ILoadM      in   3     funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010)
//  WBSelM      in   2     writeback select; 01 = load (memory read)
//  RegWEnM     in   1     register write enable from the pipeline register
//  MemRWM      in   1     1 = store
//  AddrM       in   XLEN  effective address (ALU result)
//  WDataM      in   XLEN  store data (rs2)
//  dmem_req    out  1     request valid, registered
//  dmem_we     out  1     write request, registered
//  dmem_addr   out  XLEN  word-aligned address {AddrM[XLEN-1:2],2'b00}, registered
//  dmem_wdata  out  XLEN  lane-replicated store data, registered
//  dmem_be     out  4     byte enables, registered
//  dmem_rdata  in   XLEN  read data, valid with dmem_ack
//  dmem_ack    in   1     access complete
//  LoadDataM   out  XLEN  extended load result, valid in RESP
//  RegWEnOutM  out  1     RegWEnM & ~MisalignM & ~BusErrM
//  StallM      out  1     hold IF/ID/EX and the E->M register
//  MisalignM   out  1     misaligned access flag, combinational
//  BusErrM     out  1     timeout flag, valid in RESP
// BEHAVIOUR
//  Access definition: load = WBSelM==01 && !MemRWM; store = MemRWM; both true => store wins.
//  Misaligned: H/HU/SH with AddrM[0]!=0, or W/SW with AddrM[1:0]!=0.
//    - Raises MisalignM in the same cycle, issues no request, no stall, and RegWEnOutM=0.
//  FSM states: IDLE, REQ, RESP.
//   IDLE
//    - With an aligned access: register dmem_* outputs, assert dmem_req, StallM=1, go to REQ.
//    - Otherwise: StallM=0 and dmem_req=0.
//   REQ
//    - dmem_req=1; address, data, and byte enables are held stable; StallM=1.
//    - Timeout counter increments every cycle.
//    - On dmem_ack: capture extended rdata into a register, drop dmem_req, go to RESP.
//    - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack: drop dmem_req, set error, go to RESP.
//   RESP
//    - StallM=0 and LoadDataM=captured value (0 on a store or error); BusErrM=error flag.
//    - Pipeline advances at this clock edge; next state is IDLE and the error flag clears.
//  Latency: zero-wait memory = 3 cycles in M (IDLE, REQ with ack, RESP); each wait cycle adds 1.
//  Store steering:
//    - SB: wdata={4{WDataM[7:0]}}, be=0001<<AddrM[1:0].
//    - SH: wdata={2{WDataM[15:0]}}, be=0011<<AddrM[1:0].
//    - SW: be=1111.
//  Load extraction: select the byte/half lane by AddrM[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
//  dmem_ack outside REQ is ignored; a spurious or late ack must not change state.
//  Reset value of every output is 0.
//    - Async reset from any state forces IDLE and clears the counter, error flag, and captured data.
//    - An outstanding request is abandoned.
//  StallM is forced 0 while rst is high.
//  Counter width: $clog2(TIMEOUT+1), minimum 1; cleared on entry to REQ.
// TESTING
//  1. LW at 0x100, rdata=0xDEADBEEF, ack in the first REQ cycle -> StallM high 2 cycles; RESP LoadDataM=0xDEADBEEF.
//  2. LB at 0x103, rdata=0x80FF0000 -> LoadDataM=0xFFFFFF80; LBU -> 0x00000080; LH at 0x102 -> 0xFFFF80FF.
//  3. SB at 0x101 with WDataM=0x12345678 -> dmem_be=0010, dmem_wdata=0x78787878, dmem_we=1.
//     SH at 0x102 -> be=1100, wdata=0x56785678.
//  4. LW at 0x102 -> MisalignM=1, RegWEnOutM=0, no dmem_req, StallM=0.
//  5. TIMEOUT=4 with no ack -> dmem_req high 4 cycles, then RESP with BusErrM=1, LoadDataM=0, RegWEnOutM=0.
//  6. rst asserted mid-REQ, then ack arrives after reset release in IDLE -> outputs 0, state IDLE, ack ignored.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory handshake bundle between the load/store unit (master) and memory (slave).
interface mem_access_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one variable-latency dmem access per instruction,
// stalls the pipeline until it completes, steers store lanes and extends load data.
module mem_access_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          ILoadM,
  input  logic [1:0]          WBSelM,
  input  logic                RegWEnM,
  input  logic                MemRWM,
  input  logic [XLEN-1:0]     AddrM,
  input  logic [XLEN-1:0]     WDataM,
  mem_access_unit_if.master   dmem,
  output logic [XLEN-1:0]     LoadDataM,
  output logic                RegWEnOutM,
  output logic                StallM,
  output logic                MisalignM,
  output logic                BusErrM
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lane_q, lane_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            is_store, is_load, access, misalign, go;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_be;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  // Store wins when both decodes are true.
  assign is_store = MemRWM;
  assign is_load  = (WBSelM == 2'b01) && !MemRWM;
  assign access   = is_store || is_load;
  assign misalign = access && (((ILoadM[1:0] == 2'b01) && AddrM[0]) ||
                               (ILoadM[1] && (AddrM[1:0] != 2'b00)));
  assign go       = access && !misalign;

  always_comb begin
    st_wdata = WDataM;
    st_be    = 4'b1111;
    case (ILoadM[1:0])
      2'b00: begin
        st_wdata = {4{WDataM[7:0]}};
        st_be    = 4'b0001 << AddrM[1:0];
      end
      2'b01: begin
        st_wdata = {2{WDataM[15:0]}};
        st_be    = 4'b0011 << AddrM[1:0];
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset latched at issue, not the live pipeline input.
  assign ld_byte = dmem.dmem_rdata[{lane_q, 3'b000} +: 8];
  assign ld_half = dmem.dmem_rdata[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {AddrM[XLEN-1:2], 2'b00};
          wdata_d = st_wdata;
          be_d    = st_be;
          f3_d    = ILoadM;
          lane_d  = AddrM[1:0];
          cnt_d   = '0;
          rdata_d = '0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (dmem.dmem_ack) begin
          state_d = RESP;
          req_d   = 1'b0;
          rdata_d = we_q ? '0 : ld_ext;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = RESP;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem.dmem_req   = req_q;
    dmem.dmem_we    = we_q;
    dmem.dmem_addr  = addr_q;
    dmem.dmem_wdata = wdata_q;
    dmem.dmem_be    = be_q;
    StallM          = !rst && (((state_q == IDLE) && go) || (state_q == REQ));
    MisalignM       = !rst && misalign;
    BusErrM         = err_q;
    LoadDataM       = (state_q == RESP) ? rdata_q : '0;
    RegWEnOutM      = !rst && RegWEnM && !misalign && !err_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected responses queued at issue, compared in RESP.
module tb_mem_access_unit;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ILoadM;
  logic [1:0]  WBSelM;
  logic        RegWEnM;
  logic        MemRWM;
  logic [31:0] AddrM;
  logic [31:0] WDataM;
  logic [31:0] LoadDataM;
  logic        RegWEnOutM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;

  mem_access_unit_if #(.XLEN(32)) bus ();

  mem_access_unit #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ILoadM     (ILoadM),
    .WBSelM     (WBSelM),
    .RegWEnM    (RegWEnM),
    .MemRWM     (MemRWM),
    .AddrM      (AddrM),
    .WDataM     (WDataM),
    .dmem       (bus),
    .LoadDataM  (LoadDataM),
    .RegWEnOutM (RegWEnOutM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    logic        regwe;
    int unsigned stalls;
    int unsigned reqs;
  } exp_t;

  exp_t sb[$];

  task automatic idle_inputs();
    ILoadM  = 3'b000;
    WBSelM  = 2'b00;
    RegWEnM = 1'b0;
    MemRWM  = 1'b0;
    AddrM   = '0;
    WDataM  = '0;
  endtask

  // Called at negedge+1 with the DUT in IDLE; waits<0 means memory never acks.
  task automatic access(input string tag, input logic [2:0] f3, input logic [1:0] wb,
                        input logic rw, input logic rwe, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input logic [31:0] exp_data, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_be);
    exp_t e;
    exp_t got;
    int unsigned stalls = 0;
    int unsigned reqs = 0;
    int cyc = 0;
    e.tag    = tag;
    e.err    = (waits < 0);
    e.data   = e.err ? 32'h0 : exp_data;
    e.regwe  = rwe && !e.err;
    e.reqs   = e.err ? TO : 32'(waits + 1);
    e.stalls = e.reqs + 1;
    sb.push_back(e);

    ILoadM = f3; WBSelM = wb; MemRWM = rw; RegWEnM = rwe; AddrM = addr; WDataM = wd;
    #1;
    while (StallM === 1'b1 && cyc < 40) begin
      stalls++;
      if (bus.dmem_req === 1'b1) reqs++;
      if (cyc == 1) begin
        check({tag, ".addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
        check({tag, ".we"}, 32'(bus.dmem_we), 32'(rw));
        if (rw) begin
          check({tag, ".be"}, 32'(bus.dmem_be), 32'(exp_be));
          check({tag, ".wdata"}, bus.dmem_wdata, exp_wdata);
        end
      end
      if (waits >= 0 && cyc == waits + 1) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rd;
      end
      @(negedge clk);
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = $urandom;
      #1;
      cyc++;
    end
    if (cyc >= 40) check({tag, ".stall_bound"}, 32'(StallM), 32'd0);

    got = sb.pop_front();
    check({got.tag, ".stalls"}, stalls, got.stalls);
    check({got.tag, ".reqs"}, reqs, got.reqs);
    check({got.tag, ".data"}, LoadDataM, got.data);
    check({got.tag, ".buserr"}, 32'(BusErrM), 32'(got.err));
    check({got.tag, ".regwe"}, 32'(RegWEnOutM), 32'(got.regwe));
    check({got.tag, ".req_dropped"}, 32'(bus.dmem_req), 32'd0);

    @(negedge clk);
    idle_inputs();
    #1;
    check({got.tag, ".idle_err"}, 32'(BusErrM), 32'd0);
    check({got.tag, ".idle_stall"}, 32'(StallM), 32'd0);
  endtask

  task automatic misaligned(input string tag, input logic [2:0] f3, input logic rw,
                            input logic [31:0] addr);
    ILoadM = f3; WBSelM = rw ? 2'b00 : 2'b01; MemRWM = rw; RegWEnM = !rw;
    AddrM = addr; WDataM = 32'hA5A5A5A5;
    #1;
    check({tag, ".misalign"}, 32'(MisalignM), 32'd1);
    check({tag, ".regwe"}, 32'(RegWEnOutM), 32'd0);
    check({tag, ".stall"}, 32'(StallM), 32'd0);
    @(negedge clk);
    #1;
    check({tag, ".no_req"}, 32'(bus.dmem_req), 32'd0);
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.req", 32'(bus.dmem_req), 32'd0);
    check("rst.we", 32'(bus.dmem_we), 32'd0);
    check("rst.addr", bus.dmem_addr, 32'd0);
    check("rst.wdata", bus.dmem_wdata, 32'd0);
    check("rst.be", 32'(bus.dmem_be), 32'd0);
    check("rst.load", LoadDataM, 32'd0);
    check("rst.buserr", 32'(BusErrM), 32'd0);
    ILoadM = 3'b010; WBSelM = 2'b01; RegWEnM = 1'b1; AddrM = 32'h100;
    #1;
    check("rst.stall_forced", 32'(StallM), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;

    access("lw",    3'b010, 2'b01, 1'b0, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h0, 4'h0);
    access("lb",    3'b000, 2'b01, 1'b0, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 1, 32'hFFFFFF80, 32'h0, 4'h0);
    access("lbu",   3'b100, 2'b01, 1'b0, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h00000080, 32'h0, 4'h0);
    access("lh",    3'b001, 2'b01, 1'b0, 1'b1, 32'h102, 32'h0, 32'h80FF0000, 2, 32'hFFFF80FF, 32'h0, 4'h0);
    access("lhu",   3'b101, 2'b01, 1'b0, 1'b1, 32'h102, 32'h0, 32'h80FF0000, 0, 32'h000080FF, 32'h0, 4'h0);
    access("lb1",   3'b000, 2'b01, 1'b0, 1'b1, 32'h101, 32'h0, 32'h12345678, 0, 32'h00000056, 32'h0, 4'h0);
    access("lh0",   3'b001, 2'b01, 1'b0, 1'b1, 32'h100, 32'h0, 32'h00017FFE, 0, 32'h00007FFE, 32'h0, 4'h0);
    access("sb",    3'b000, 2'b00, 1'b1, 1'b0, 32'h101, 32'h12345678, 32'hAAAA5555, 0, 32'h0, 32'h78787878, 4'b0010);
    access("sh",    3'b001, 2'b00, 1'b1, 1'b0, 32'h102, 32'h12345678, 32'hAAAA5555, 1, 32'h0, 32'h56785678, 4'b1100);
    access("sw_wb", 3'b010, 2'b01, 1'b1, 1'b0, 32'h104, 32'h12345678, 32'hAAAA5555, 0, 32'h0, 32'h12345678, 4'b1111);

    misaligned("mis_lw", 3'b010, 1'b0, 32'h102);
    misaligned("mis_lh", 3'b001, 1'b0, 32'h101);
    misaligned("mis_sh", 3'b001, 1'b1, 32'h103);
    misaligned("mis_sw", 3'b010, 1'b1, 32'h101);
    WBSelM = 2'b00; ILoadM = 3'b010; AddrM = 32'h103; RegWEnM = 1'b1;
    #1;
    check("noacc.misalign", 32'(MisalignM), 32'd0);
    check("noacc.stall", 32'(StallM), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;

    access("timeout", 3'b010, 2'b01, 1'b0, 1'b1, 32'h108, 32'h0, 32'h0, -1, 32'h0, 32'h0, 4'h0);

    ILoadM = 3'b010; WBSelM = 2'b01; RegWEnM = 1'b1; AddrM = 32'h200;
    #1;
    check("rstreq.stall", 32'(StallM), 32'd1);
    @(negedge clk);
    #1;
    check("rstreq.req_before", 32'(bus.dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rstreq.req_abandoned", 32'(bus.dmem_req), 32'd0);
    check("rstreq.stall", 32'(StallM), 32'd0);
    check("rstreq.addr", bus.dmem_addr, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    #1;
    check("lateack.req", 32'(bus.dmem_req), 32'd0);
    check("lateack.stall", 32'(StallM), 32'd0);
    check("lateack.load", LoadDataM, 32'd0);
    check("lateack.buserr", 32'(BusErrM), 32'd0);
    access("post_rst", 3'b010, 2'b01, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0BADF00D, 0, 32'h0BADF00D, 32'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
